// File: rtl/fu_complete_buffer_pkg.sv
// Shared types, sizes and helpers for the FU completion buffer and the CDB.
package fu_complete_buffer_pkg;

  localparam int unsigned NUM_ROB   = 32;
  localparam int unsigned NUM_PR    = 64;
  localparam int unsigned NUM_FU    = 4;

  localparam int unsigned ROB_W     = $clog2(NUM_ROB);
  localparam int unsigned PR_W      = $clog2(NUM_PR);
  localparam int unsigned AR_W      = 5;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned FCB_DEPTH = 4;

  // One buffered FU result
  typedef struct packed {
    logic              valid;
    logic [PR_W-1:0]   T;
    logic [ROB_W-1:0]  ROB_idx;
    logic [AR_W-1:0]   dest_idx;
    logic [DATA_W-1:0] result;
  } FU_COMPLETE_ENTRY_t;

  // Modular ROB distance from base to idx; wraps at NUM_ROB
  function automatic logic [ROB_W-1:0] rob_dist(input logic [ROB_W-1:0] idx,
                                                input logic [ROB_W-1:0] base);
    return idx - base;
  endfunction

endpackage

// File: rtl/fu_complete_buffer_compact.sv
// Collapses kept entries toward slot 0, preserving their relative order.
module fu_complete_buffer_compact
  import fu_complete_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = FCB_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]   i_keep,
  input  FU_COMPLETE_ENTRY_t i_entries [DEPTH],
  output FU_COMPLETE_ENTRY_t o_entries [DEPTH],
  output logic [CNT_W-1:0]   o_count
);

  // Walk slots in order, placing each kept entry at the next free output slot
  always_comb begin
    logic [CNT_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_entries[i] = '0;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_keep[i]) begin
        o_entries[n[IDX_W-1:0]] = i_entries[i];
        n = n + 1'b1;
      end
    end
    o_count = n;
  end

endmodule

// File: rtl/fu_complete_buffer.sv
// Per-FU completion queue feeding one CDB slot; squashes on rollback.
module fu_complete_buffer
  import fu_complete_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = FCB_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fu_valid,
  input  logic [PR_W-1:0]   fu_T_idx,
  input  logic [ROB_W-1:0]  fu_ROB_idx,
  input  logic [AR_W-1:0]   fu_dest_idx,
  input  logic [DATA_W-1:0] fu_result,
  output logic              fu_ready,
  input  logic              cdb_free,
  output logic              FU_done,
  output logic [PR_W-1:0]   T_idx,
  output logic [ROB_W-1:0]  ROB_idx,
  output logic [AR_W-1:0]   dest_idx,
  output logic [DATA_W-1:0] FU_result,
  input  logic              rollback_en,
  input  logic [ROB_W-1:0]  ROB_rollback_idx,
  input  logic [ROB_W-1:0]  diff_ROB,
  output logic [CNT_W-1:0]  count
);

  FU_COMPLETE_ENTRY_t r_slots   [DEPTH];
  FU_COMPLETE_ENTRY_t w_compact [DEPTH];
  FU_COMPLETE_ENTRY_t w_next    [DEPTH];
  FU_COMPLETE_ENTRY_t w_in;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_surv;
  logic [CNT_W-1:0]   w_count_next;
  logic [DEPTH-1:0]   w_valid;
  logic [DEPTH-1:0]   w_squash;
  logic [DEPTH-1:0]   w_keep;
  logic               w_squash_in;
  logic               w_pop;
  logic               w_push;

  // Per-slot squash and survivor mask; head is dropped when popped
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_valid[i]  = r_slots[i].valid;
      w_squash[i] = rollback_en &&
                    (diff_ROB >= rob_dist(r_slots[i].ROB_idx, ROB_rollback_idx));
      w_keep[i]   = w_valid[i] && !w_squash[i] && !((i == 0) && w_pop);
    end
  end

  // Head offer is independent of cdb_free; transfer needs both
  always_comb begin
    FU_done = r_slots[0].valid && !w_squash[0];
    w_pop   = FU_done && cdb_free;
  end

  // Incoming result packaging and acceptance
  always_comb begin
    w_in.valid    = 1'b1;
    w_in.T        = fu_T_idx;
    w_in.ROB_idx  = fu_ROB_idx;
    w_in.dest_idx = fu_dest_idx;
    w_in.result   = fu_result;
    w_squash_in   = rollback_en &&
                    (diff_ROB >= rob_dist(fu_ROB_idx, ROB_rollback_idx));
    w_push        = fu_valid && fu_ready && !w_squash_in;
  end

  fu_complete_buffer_compact #(
    .DEPTH (DEPTH)
  ) u_compact (
    .i_keep    (w_keep),
    .i_entries (r_slots),
    .o_entries (w_compact),
    .o_count   (w_surv)
  );

  // Append the accepted push right after the compacted survivors
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_next[i] = w_compact[i];
    end
    if (w_push && (w_surv < CNT_W'(DEPTH))) begin
      w_next[w_surv[IDX_W-1:0]] = w_in;
    end
    w_count_next = w_surv + CNT_W'(w_push);
  end

  // Queue state and occupancy registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_slots[i] <= '0;
      end
      r_count <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_slots[i] <= w_next[i];
      end
      r_count <= w_count_next;
    end
  end

  assign fu_ready  = (r_count < CNT_W'(DEPTH));
  assign count     = r_count;
  assign T_idx     = r_slots[0].T;
  assign ROB_idx   = r_slots[0].ROB_idx;
  assign dest_idx  = r_slots[0].dest_idx;
  assign FU_result = r_slots[0].result;

  a_count_bound : assert property (@(posedge clock) disable iff (reset)
    r_count <= CNT_W'(DEPTH));

  a_contiguous : assert property (@(posedge clock) disable iff (reset)
    ((w_valid + DEPTH'(1)) & w_valid) == '0);

  a_fu_protocol : assert property (@(posedge clock) disable iff (reset)
    !(fu_valid && !fu_ready));

endmodule

// File: tb/tb_fu_complete_buffer.sv
// Scoreboard bench: drivers queue expected CDB transfers, a monitor checks them.
module tb_fu_complete_buffer;
  import fu_complete_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              reset;
  logic              fu_valid;
  logic [PR_W-1:0]   fu_T_idx;
  logic [ROB_W-1:0]  fu_ROB_idx;
  logic [AR_W-1:0]   fu_dest_idx;
  logic [DATA_W-1:0] fu_result;
  logic              fu_ready;
  logic              cdb_free;
  logic              FU_done;
  logic [PR_W-1:0]   T_idx;
  logic [ROB_W-1:0]  ROB_idx;
  logic [AR_W-1:0]   dest_idx;
  logic [DATA_W-1:0] FU_result;
  logic              rollback_en;
  logic [ROB_W-1:0]  ROB_rollback_idx;
  logic [ROB_W-1:0]  diff_ROB;
  logic [CNT_W-1:0]  count;

  typedef struct {
    logic [PR_W-1:0]   t;
    logic [ROB_W-1:0]  rob;
    logic [AR_W-1:0]   dest;
    logic [DATA_W-1:0] res;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  fu_complete_buffer #(.DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .fu_valid         (fu_valid),
    .fu_T_idx         (fu_T_idx),
    .fu_ROB_idx       (fu_ROB_idx),
    .fu_dest_idx      (fu_dest_idx),
    .fu_result        (fu_result),
    .fu_ready         (fu_ready),
    .cdb_free         (cdb_free),
    .FU_done          (FU_done),
    .T_idx            (T_idx),
    .ROB_idx          (ROB_idx),
    .dest_idx         (dest_idx),
    .FU_result        (FU_result),
    .rollback_en      (rollback_en),
    .ROB_rollback_idx (ROB_rollback_idx),
    .diff_ROB         (diff_ROB),
    .count            (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one FU result for the coming edge and optionally expect it on the CDB
  task automatic drive(input int t, input int rob, input int dest,
                       input logic [63:0] res, input bit expect_it);
    exp_t e;
    fu_valid    = 1'b1;
    fu_T_idx    = PR_W'(t);
    fu_ROB_idx  = ROB_W'(rob);
    fu_dest_idx = AR_W'(dest);
    fu_result   = res;
    if (expect_it) begin
      e.t = PR_W'(t); e.rob = ROB_W'(rob); e.dest = AR_W'(dest); e.res = res;
      q.push_back(e);
    end
  endtask

  // Monitor: each CDB transfer must match the oldest expected entry
  always @(negedge clock) begin
    if (!reset && FU_done && cdb_free) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_xfer: got T=%0d with empty scoreboard at %0t", T_idx, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("xfer_T", 64'(T_idx), 64'(e.t));
        chk("xfer_ROB", 64'(ROB_idx), 64'(e.rob));
        chk("xfer_dest", 64'(dest_idx), 64'(e.dest));
        chk("xfer_result", FU_result, e.res);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; fu_valid = 1'b0; fu_T_idx = '0; fu_ROB_idx = '0;
    fu_dest_idx = '0; fu_result = '0; cdb_free = 1'b0; rollback_en = 1'b0;
    ROB_rollback_idx = '0; diff_ROB = '0;
    #3;
    chk("rst_count", 64'(count), 0);
    chk("rst_ready", 64'(fu_ready), 1);
    chk("rst_done", 64'(FU_done), 0);
    chk("rst_T", 64'(T_idx), 0);
    chk("rst_result", FU_result, 0);
    tick();
    reset = 1'b0;

    // Single push into empty buffer, popped the following cycle
    cdb_free = 1'b1;
    drive(5, 3, 7, 64'hAA, 1'b1);
    tick();
    fu_valid = 1'b0;
    chk("t1_done", 64'(FU_done), 1);
    chk("t1_T", 64'(T_idx), 5);
    chk("t1_count", 64'(count), 1);
    tick();
    chk("t1_count_after", 64'(count), 0);
    chk("t1_done_after", 64'(FU_done), 0);

    // Fill to full while the CDB is busy, then drain in order
    cdb_free = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(i, i, i, 64'h100 + 64'(i), 1'b1);
      tick();
    end
    fu_valid = 1'b0;
    chk("t2_count_full", 64'(count), 4);
    chk("t2_ready_full", 64'(fu_ready), 0);
    chk("t2_done_held", 64'(FU_done), 1);
    cdb_free = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t2_count_drained", 64'(count), 0);
    chk("t2_ready_drained", 64'(fu_ready), 1);

    // Rollback from ROB 12, distance 3: squashes 12 and 14, keeps 10 and 16
    cdb_free = 1'b0;
    drive(10, 10, 1, 64'h10, 1'b1); tick();
    drive(12, 12, 2, 64'h12, 1'b1); tick();
    drive(14, 14, 3, 64'h14, 1'b1); tick();
    drive(16, 16, 4, 64'h16, 1'b1); tick();
    fu_valid = 1'b0;
    rollback_en = 1'b1; ROB_rollback_idx = 5'd12; diff_ROB = 5'd3;
    chk("t3_head_live", 64'(FU_done), 1);
    tick();
    rollback_en = 1'b0;
    q.delete(2);
    q.delete(1);
    chk("t3_count", 64'(count), 2);
    chk("t3_head", 64'(ROB_idx), 10);
    cdb_free = 1'b1;
    tick(); tick();
    chk("t3_count_drained", 64'(count), 0);

    // Wrap: rollback at 31, distance 5 squashes ROB 1 (dist 2), keeps 30 (dist 31)
    cdb_free = 1'b0;
    drive(30, 30, 5, 64'h30, 1'b1); tick();
    drive(33, 1, 6, 64'h01, 1'b1); tick();
    fu_valid = 1'b0;
    rollback_en = 1'b1; ROB_rollback_idx = 5'd31; diff_ROB = 5'd5;
    tick();
    rollback_en = 1'b0;
    q.delete(1);
    chk("t4_count", 64'(count), 1);
    chk("t4_head", 64'(ROB_idx), 30);
    cdb_free = 1'b1;
    tick();
    chk("t4_count_drained", 64'(count), 0);

    // Squashed head with free CDB, plus a squashed incoming push
    cdb_free = 1'b0;
    drive(20, 20, 7, 64'h20, 1'b1); tick();
    drive(8, 8, 8, 64'h08, 1'b1); tick();
    cdb_free = 1'b1;
    rollback_en = 1'b1; ROB_rollback_idx = 5'd20; diff_ROB = 5'd2;
    drive(21, 21, 9, 64'h21, 1'b0);
    #1;
    chk("t5_done_squashed", 64'(FU_done), 0);
    chk("t5_head_fields", 64'(T_idx), 20);
    tick();
    fu_valid = 1'b0;
    rollback_en = 1'b0;
    q.delete(0);
    chk("t5_count", 64'(count), 1);
    chk("t5_head", 64'(T_idx), 8);
    tick();
    chk("t5_count_drained", 64'(count), 0);

    // Asynchronous reset between edges with three entries held
    cdb_free = 1'b0;
    drive(1, 1, 1, 64'h1, 1'b0); tick();
    drive(2, 2, 2, 64'h2, 1'b0); tick();
    drive(3, 3, 3, 64'h3, 1'b0); tick();
    fu_valid = 1'b0;
    chk("t6_count_pre", 64'(count), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_count_async", 64'(count), 0);
    chk("t6_done_async", 64'(FU_done), 0);
    chk("t6_ready_async", 64'(fu_ready), 1);
    chk("t6_T_async", 64'(T_idx), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_count_post", 64'(count), 0);

    chk("scoreboard_empty", 64'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fu_complete_buffer.md
Name: fu_complete_buffer

Overview:
- Per-FU completion queue between a functional unit's final stage and one CDB slot. It is the transmitter side of the CDB's FU_done/CDB_valid handshake.
- Buffers finished results (tag, ROB index, destination, value) and presents the oldest-arrived entry to the CDB. It retires that entry when the CDB slot is free.
- Squashes entries on branch rollback using the same ROB-distance rule as the CDB.
- Backpressures the FU with a ready signal when full.

Parameters:
- DEPTH, 4, number of buffered results (power of two not required, >=2).
- ROB_W, 5, ROB index width ($clog2(NUM_ROB), NUM_ROB=32).
- PR_W, 6, physical-register tag width (NUM_PR=64).
- AR_W, 5, architectural dest_idx width.
- DATA_W, 64, result width.

Ports:
- clock in 1 system clock, rising edge
- reset in 1 asynchronous, active-high; clears all state immediately
- fu_valid in 1 FU presents a finished result this cycle
- fu_T_idx in PR_W destination physical tag
- fu_ROB_idx in ROB_W ROB index of the instruction
- fu_dest_idx in AR_W architectural destination
- fu_result in DATA_W result value
- fu_ready out 1 buffer can accept a result this cycle
- cdb_free in 1 CDB slot for this FU is empty; derived from CDB register state only
- FU_done out 1 head entry valid and offered to the CDB
- T_idx out PR_W head tag
- ROB_idx out ROB_W head ROB index
- dest_idx out AR_W head arch destination
- FU_result out DATA_W head value
- rollback_en in 1 rollback this cycle
- ROB_rollback_idx in ROB_W ROB index of the mispredicted instruction
- diff_ROB in ROB_W ROB_tail minus ROB_rollback_idx, modulo NUM_ROB
- count out $clog2(DEPTH+1) number of valid entries (registered)

Behaviour:
- Storage is a collapsing queue: slots 0..DEPTH-1 with a valid bit each. Slot 0 is the head; arrival order is preserved and no holes are allowed.
- Reset (asynchronous): all valid=0, count=0, fu_ready=1, FU_done=0. T_idx, ROB_idx, dest_idx and FU_result are all 0. Reset mid-operation drops every entry with no CDB transfer.
- Squash test for any entry e: squash(e) = rollback_en && (diff_ROB >= ((e.ROB_idx - ROB_rollback_idx) mod 2^ROB_W)). The subtraction is ROB_W bits and wraps.
- FU_done = slot0.valid && !squash(slot0). Head fields drive outputs directly whether or not FU_done is asserted. This is combinational from rollback inputs.
- fu_done must not depend on cdb_free. The pop condition is pop = FU_done && cdb_free.
- fu_ready = (count < DEPTH), from registered state only. There is no same-cycle push-through when full, even if a pop occurs.
- Push accepted = fu_valid && fu_ready && !squash(incoming). A squashed incoming result is dropped silently.
- Next state each cycle, in order:
  - (1) Survivors are valid slots, excluding slot 0 if popped, excluding any squashed slot.
  - (2) Compact survivors toward slot 0 in original order.
  - (3) Append the accepted push at the first free slot.
- count_next = survivors + push.
- Latency: a push into an empty buffer is visible on FU_done the next cycle (1-cycle minimum). A pop and a push in the same cycle are legal.
- The buffer never presents a squashed entry. A rollback squashing every entry yields count=0 next cycle.
- Tag wrap: ROB_idx comparison is modulo only. With diff_ROB=0, only the entry whose ROB_idx equals ROB_rollback_idx is squashed.
- Assertions:
  - count <= DEPTH.
  - Valid bits are contiguous from slot 0.
  - fu_valid with fu_ready=0 is an FU protocol error; the FU must hold its result.

Decomposition:
- Shared package: extend the existing CDB_entry_t use with a FU_COMPLETE_ENTRY_t struct {valid, T, ROB_idx, dest_idx, result}. Also add a package function rob_dist(idx, base) returning the ROB_W-bit modular difference, reused by the CDB and this block.
- NUM_ROB, NUM_PR and NUM_FU come from the existing sys_defs constants.
- One natural sub-module is fu_cb_compact: combinational keep-mask plus entry array in, compacted array plus survivor count out.
- The CDB instantiates NUM_FU of these blocks, one per FU.

Test Plan:
- Reset, then push T=5 ROB=3 result=0xAA with cdb_free=1. Required: FU_done=1 with T_idx=5 on the next cycle, popped that cycle, count returns to 0.
- cdb_free=0, push T=1,2,3,4 on consecutive cycles. Required: count=4 and fu_ready=0; then, with cdb_free=1 held, FU_done drains T=1,2,3,4 in order over 4 cycles.
- Fill with ROB 10,12,14,16, then rollback with ROB_rollback_idx=12 and diff_ROB=3. Required: entries 12 and 14 are squashed, 16 is kept, and the queue next cycle is 10,16 with count=2.
- ROB wrap case: entries ROB 30,1, rollback_idx=31, diff_ROB=5. Required: 1 is squashed (distance 2), 30 is kept (distance 31).
- Head squashed with cdb_free=1 in the same cycle. Required: FU_done=0 that cycle, no pop, entry gone next cycle. A same-cycle incoming push with squashed ROB is dropped.
- Assert reset asynchronously between clock edges with 3 entries. Required: count=0 and FU_done=0 immediately, before the next edge.
